// File: rtl/bus_ctrl_pkg.sv
// Shared types and default address map for the 65C02 bus controller.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_VDP,
    REG_PORT,
    REG_RAM,
    REG_NONE
  } region_e;

  localparam logic [7:0]  UNMAPPED_DATA  = 8'hFF;
  localparam logic [15:0] DEF_PORT_BASE  = 16'h8400;
  localparam logic [15:0] DEF_VDP_BASE   = 16'hF7FC;
  localparam int unsigned DEF_ROM_ADDR_W = 11;
  localparam int unsigned DEF_RAM_ADDR_W = 15;

endpackage

// File: rtl/bus_clk_phase.sv
// CPU clock divider, phase-position ticks and post-reset CPU reset stretcher.
module bus_clk_phase
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned CPU_DIV_W      = 4,
  parameter int unsigned CPU_RST_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_cpu_clk,
  output logic o_cpu_mem_clk,
  output logic o_cpu_reset,
  output logic o_low_phase,
  output logic o_tick_first,
  output logic o_tick_cap,
  output logic o_tick_last
);

  localparam int unsigned H     = 2 ** (CPU_DIV_W - 1);
  localparam int unsigned RST_W = $clog2(CPU_RST_CYCLES + 1);

  logic [CPU_DIV_W-1:0] r_ctr;
  logic [RST_W-1:0]     r_rst_cnt;
  logic                 r_cpu_reset;
  logic                 w_tick_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ctr <= '0;
    else       r_ctr <= r_ctr + CPU_DIV_W'(1);
  end

  assign w_tick_wrap   = &r_ctr;
  assign o_tick_first  = (r_ctr == '0);
  assign o_tick_cap    = (r_ctr == CPU_DIV_W'(1));
  assign o_tick_last   = (r_ctr == CPU_DIV_W'(H - 1));
  assign o_low_phase   = ~r_ctr[CPU_DIV_W-1];
  assign o_cpu_clk     = r_ctr[CPU_DIV_W-1];
  assign o_cpu_mem_clk = r_ctr[CPU_DIV_W-2];
  assign o_cpu_reset   = r_cpu_reset;

  // Count completed CPU cycles after release; reset drops on the last wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_cnt   <= '0;
      r_cpu_reset <= 1'b1;
    end else if (w_tick_wrap && r_cpu_reset) begin
      if (r_rst_cnt == RST_W'(CPU_RST_CYCLES - 1)) r_cpu_reset <= 1'b0;
      else                                           r_rst_cnt   <= r_rst_cnt + RST_W'(1);
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// 65C02 bus controller: address decode, phase-aligned strobes, port latches, read data.
// Optional port readback enabled by defining BUS_CTRL_PORT_READBACK_EN.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned CPU_DIV_W      = 4,
  parameter int unsigned NUM_PORTS      = 2,
  parameter logic [15:0] PORT_BASE      = DEF_PORT_BASE,
  parameter logic [15:0] VDP_BASE       = DEF_VDP_BASE,
  parameter int unsigned ROM_ADDR_W     = DEF_ROM_ADDR_W,
  parameter int unsigned RAM_ADDR_W     = DEF_RAM_ADDR_W,
  parameter int unsigned CPU_RST_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   cpu_clk,
  output logic                   cpu_mem_clk,
  output logic                   cpu_reset,
  input  logic [15:0]            cpu_addr,
  input  logic                   cpu_we,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             cpu_din,
  input  logic [7:0]             rom_data,
  input  logic [7:0]             ram_data,
  input  logic [7:0]             vdp_data,
  output logic                   ram_we,
  output logic                   vdp_read,
  output logic                   vdp_write,
  output logic [1:0]             vdp_mode,
  output logic [8*NUM_PORTS-1:0] io_port
);

  localparam logic [15:0] ROM_MASK = 16'hFFFF << ROM_ADDR_W;
  localparam logic [16:0] PORT_END = 17'(PORT_BASE) + 17'(NUM_PORTS);
  localparam logic [16:0] RAM_END  = 17'(1) << RAM_ADDR_W;

  logic                   w_low_phase;
  logic                   w_tick_first;
  logic                   w_tick_cap;
  logic                   w_tick_last;
  logic                   w_active;
  logic                   w_port_we;
  logic [2:0]             w_port_idx;
  logic [7:0]             w_rd_data;
  region_e                w_region;
  logic [7:0]             r_cpu_din;
  logic [7:0]             r_vdp_hold;
  logic [8*NUM_PORTS-1:0] r_io_port;

  bus_clk_phase #(
    .CPU_DIV_W      (CPU_DIV_W),
    .CPU_RST_CYCLES (CPU_RST_CYCLES)
  ) u_clk_phase (
    .i_clk         (clk),
    .i_rst         (reset),
    .o_cpu_clk     (cpu_clk),
    .o_cpu_mem_clk (cpu_mem_clk),
    .o_cpu_reset   (cpu_reset),
    .o_low_phase   (w_low_phase),
    .o_tick_first  (w_tick_first),
    .o_tick_cap    (w_tick_cap),
    .o_tick_last   (w_tick_last)
  );

  assign w_port_idx = 3'(cpu_addr - PORT_BASE);

  always_comb begin
    w_region = REG_NONE;
    if ((cpu_addr & ROM_MASK) == ROM_MASK)                                w_region = REG_ROM;
    else if (cpu_addr[15:2] == VDP_BASE[15:2])                            w_region = REG_VDP;
    else if (17'(cpu_addr) >= 17'(PORT_BASE) && 17'(cpu_addr) < PORT_END) w_region = REG_PORT;
    else if (17'(cpu_addr) < RAM_END)                                     w_region = REG_RAM;
  end

  // Strobes are forced low while reset is held, since ctr sits at 0 then.
  assign w_active  = ~reset;
  assign ram_we    = w_active & cpu_we & (w_region == REG_RAM) & w_low_phase;
  assign vdp_read  = w_active & ~cpu_we & (w_region == REG_VDP) & w_tick_first;
  assign vdp_write = w_active & cpu_we & (w_region == REG_VDP) & w_tick_last;
  assign vdp_mode  = cpu_addr[1:0];
  assign w_port_we = cpu_we & (w_region == REG_PORT) & w_tick_last;

  always_comb begin
    w_rd_data = UNMAPPED_DATA;
    case (w_region)
      REG_ROM: w_rd_data = rom_data;
      // Bypass the holding register when capture and update share an edge.
      REG_VDP: w_rd_data = w_tick_cap ? vdp_data : r_vdp_hold;
      REG_PORT: begin
`ifdef BUS_CTRL_PORT_READBACK_EN
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (w_port_idx == 3'(i)) w_rd_data = r_io_port[8*i +: 8];
        end
`else
        w_rd_data = UNMAPPED_DATA;
`endif
      end
      REG_RAM: w_rd_data = ram_data;
      default: w_rd_data = UNMAPPED_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_din  <= 8'h00;
      r_vdp_hold <= 8'h00;
      r_io_port  <= '0;
    end else begin
      if (w_tick_cap) r_vdp_hold <= vdp_data;
      if (w_tick_last && !cpu_we) r_cpu_din <= w_rd_data;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_port_we && w_port_idx == 3'(i)) r_io_port[8*i +: 8] <= cpu_dout;
      end
    end
  end

  assign cpu_din = r_cpu_din;
  assign io_port = r_io_port;

endmodule

// File: tb/tb_bus_ctrl.sv
// Randomized self-checking bench for bus_ctrl against an address-map reference model.
module tb_bus_ctrl;

  localparam int CYC = 16;
  localparam int H   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_clk, cpu_mem_clk, cpu_reset;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_dout, cpu_din, rom_data, ram_data, vdp_data;
  logic        ram_we, vdp_read, vdp_write;
  logic [1:0]  vdp_mode;
  logic [15:0] io_port;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] m_port [2];
  logic [7:0] m_din;
  int         m_cycles;

  bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_clk     (cpu_clk),
    .cpu_mem_clk (cpu_mem_clk),
    .cpu_reset   (cpu_reset),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .rom_data    (rom_data),
    .ram_data    (ram_data),
    .vdp_data    (vdp_data),
    .ram_we      (ram_we),
    .vdp_read    (vdp_read),
    .vdp_write   (vdp_write),
    .vdp_mode    (vdp_mode),
    .io_port     (io_port)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 rom, 1 vdp, 2 port, 3 ram, 4 unmapped
  function automatic int region(input logic [15:0] a);
    if (a >= 16'hF800)                  return 0;
    if (a >= 16'hF7FC)                  return 1;
    if (a == 16'h8400 || a == 16'h8401) return 2;
    if (a < 16'h8000)                   return 3;
    return 4;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] edges [8];
    edges = '{16'h83FF, 16'h8402, 16'h7FFF, 16'h8000, 16'hF7FB, 16'hF7FF, 16'hF800, 16'h0000};
    case ($urandom_range(0, 6))
      0:       return 16'hF800 + 16'($urandom_range(0, 2047));
      1:       return 16'hF7FC + 16'($urandom_range(0, 3));
      2:       return 16'h8400 + 16'($urandom_range(0, 1));
      3:       return 16'($urandom_range(0, 16'h7FFF));
      4:       return 16'($urandom_range(16'h8402, 16'hF7FB));
      5:       return 16'($urandom_range(16'h8000, 16'h83FF));
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  // One CPU cycle; entered and left just after the edge that starts ctr==0.
  task automatic do_cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
    int         rg;
    logic [7:0] rom_v, ram_v, vdp_v, rd;
    logic [2:0] e_ph;
    logic [4:0] e_st;
    rg    = region(a);
    rom_v = 8'($urandom);
    ram_v = 8'($urandom);
    vdp_v = 8'($urandom);
    cpu_addr = a; cpu_we = w; cpu_dout = d;
    rom_data = rom_v; ram_data = ram_v; vdp_data = vdp_v;
    #1;
    for (int j = 0; j < CYC; j++) begin
      e_ph = {j >= H, (j % 8) >= 4, m_cycles < 8};
      e_st = {w && rg == 3 && j < H, !w && rg == 1 && j == 0, w && rg == 1 && j == H - 1, a[1:0]};
      check("phase", {cpu_clk, cpu_mem_clk, cpu_reset}, e_ph);
      check("strobes", {ram_we, vdp_read, vdp_write, vdp_mode}, e_st);
      check("cpu_din", cpu_din, m_din);
      check("io_port", io_port, {m_port[1], m_port[0]});
      @(posedge clk);
      #1;
      if (j == 1) vdp_data = ~vdp_v;
      if (j == H - 1) begin
        if (w && rg == 2) m_port[int'(a - 16'h8400)] = d;
        if (!w) begin
          case (rg)
            0: rd = rom_v;
            1: rd = vdp_v;
`ifdef BUS_CTRL_PORT_READBACK_EN
            2: rd = m_port[int'(a - 16'h8400)];
`else
            2: rd = 8'hFF;
`endif
            3: rd = ram_v;
            default: rd = 8'hFF;
          endcase
          m_din = rd;
        end
      end
      if (j == CYC - 1) m_cycles++;
    end
  endtask

  task automatic model_reset();
    m_port[0] = 8'h00;
    m_port[1] = 8'h00;
    m_din     = 8'h00;
    m_cycles  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_phase"}, {cpu_clk, cpu_mem_clk, cpu_reset}, 3'b001);
    check({tag, "_strobes"}, {ram_we, vdp_read, vdp_write}, 3'b000);
    check({tag, "_din"}, cpu_din, 8'h00);
    check({tag, "_io"}, io_port, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 16'hF7FD; cpu_we = 1'b0; cpu_dout = 8'h00;
    rom_data = 8'h00; ram_data = 8'h00; vdp_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_vdp_rd");
    cpu_addr = 16'h1234; cpu_we = 1'b1;
    #1;
    check_reset_state("rst_ram_wr");
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_cycle(16'h8401, 1'b1, 8'hA5);
    do_cycle(16'hF7FD, 1'b0, 8'h00);
    do_cycle(16'hFFFC, 1'b0, 8'h00);
    do_cycle(16'h9000, 1'b0, 8'h00);
    do_cycle(16'h1234, 1'b1, 8'h77);
    do_cycle(16'h8400, 1'b1, 8'h5A);
    do_cycle(16'h8400, 1'b0, 8'h00);
    do_cycle(16'hFFFC, 1'b1, 8'h11);
    do_cycle(16'h9000, 1'b1, 8'h22);
    do_cycle(16'hF7FE, 1'b1, 8'h33);
    do_cycle(16'h8402, 1'b1, 8'h44);
    do_cycle(16'h83FF, 1'b1, 8'h55);
    do_cycle(16'h7FFF, 1'b1, 8'h66);
    do_cycle(16'h8401, 1'b0, 8'h00);

    for (int k = 0; k < 60; k++) do_cycle(rand_addr(), 1'($urandom), 8'($urandom));

    // Reset asserted at ctr==5 in the middle of a port write.
    do_cycle(16'h8400, 1'b1, 8'h96);
    cpu_addr = 16'h8400; cpu_we = 1'b1; cpu_dout = 8'hC3;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_state("midrst");
    cpu_addr = 16'hF7FD; cpu_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_reset_state("midrst_hold");
    end
    reset = 1'b0;

    for (int k = 0; k < 40; k++) do_cycle(rand_addr(), 1'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Parametrised CPU bus controller for the 65C02 system. Generalises the divider, decode and strobe logic that currently sits inline in the top level.
- Derives the CPU clock phases from the single system clock and decodes ROM, RAM, VDP and a bank of N output ports.
- Generates phase-aligned single-cycle read/write strobes and registers CPU read data.
- Sits between cpu_65c02 and the memory/VDP instances. All logic is in the clk domain; no logic is clocked by cpu_clk.

Parameters:
- CPU_DIV_W, 4: divider width; one CPU cycle = 2^CPU_DIV_W clk cycles; minimum 2.
- NUM_PORTS, 2: number of 8-bit output ports, 1..8.
- PORT_BASE, 16'h8400: address of port 0; port i is at PORT_BASE+i.
- VDP_BASE, 16'hF7FC: VDP window base; 4 bytes; must be 4-aligned.
- ROM_ADDR_W, 11: ROM occupies the top 2^ROM_ADDR_W bytes.
- RAM_ADDR_W, 15: RAM occupies addresses 0 .. 2^RAM_ADDR_W-1.
- CPU_RST_CYCLES, 8: CPU cycles cpu_reset is held after reset is released.

Ports:
- clk in 1: system/memory clock.
- reset in 1: asynchronous, active-high system reset.
- cpu_clk out 1: CPU clock.
- cpu_mem_clk out 1: half-period-phase memory clock.
- cpu_reset out 1: CPU reset.
- cpu_addr in 16: CPU address bus.
- cpu_we in 1: CPU write enable.
- cpu_dout in 8: CPU write data.
- cpu_din out 8: registered CPU read data.
- rom_data in 8: ROM read data.
- ram_data in 8: RAM read data.
- vdp_data in 8: VDP read data.
- ram_we out 1: RAM write enable.
- vdp_read out 1: VDP read strobe.
- vdp_write out 1: VDP write strobe.
- vdp_mode out 2: VDP register select, equal to cpu_addr[1:0].
- io_port out 8*NUM_PORTS: output port latches; port i occupies bits [8i+7:8i].

Behaviour:
- Divider:
  - ctr (CPU_DIV_W bits) resets to 0 and increments every clk, wrapping.
  - cpu_clk = ctr[MSB]; cpu_mem_clk = ctr[MSB-1].
  - Low phase is ctr = 0..H-1, where H = 2^(CPU_DIV_W-1).
- Decode priority: ROM (addr[15:ROM_ADDR_W] all ones) > VDP (addr[15:2]==VDP_BASE[15:2]) > port (PORT_BASE <= addr < PORT_BASE+NUM_PORTS) > RAM (addr < 2^RAM_ADDR_W) > unmapped.
- ram_we: combinational; = cpu_we & RAM selected & low phase.
- vdp_read: one-clk pulse at ctr==0 when VDP is selected and cpu_we=0. Never held across the whole phase, so VDP FIFO side effects happen exactly once.
- vdp_data capture: registered at ctr==1 into a holding register.
- vdp_write: one-clk pulse at ctr==H-1 when VDP is selected and cpu_we=1.
- Port write: port i loads cpu_dout at ctr==H-1 when cpu_we=1 and the address is PORT_BASE+i. Exactly one latch event per CPU cycle.
- cpu_din:
  - Updated at the clk edge where ctr==H-1, so it is stable before cpu_clk rises.
  - Source by decode: rom_data / VDP holding register / port readback (see optional feature) / ram_data / 8'hFF when unmapped.
- cpu_reset:
  - Asserted by reset.
  - After reset is released, counts CPU_RST_CYCLES completed CPU cycles (counted at ctr wraps), then deasserts and stays low.
- Reset values (async, any time including mid-cycle):
  - ctr=0, cpu_clk=0, cpu_mem_clk=0, cpu_reset=1.
  - cpu_din=8'h00, io_port all 0, VDP holding register 0.
  - All strobes are 0 and are gated off during reset.
- Write-only (ROM-selected) writes and unmapped accesses: no strobes, no state change.

Optional Feature:
- Macro: BUS_CTRL_PORT_READBACK_EN.
- Defined: a read of PORT_BASE+i returns io_port[i].
- Undefined: port addresses read as 8'hFF, and the readback mux is not built.

Decomposition:
- Package bus_ctrl_pkg holds:
  - the region enum (REG_ROM, REG_VDP, REG_PORT, REG_RAM, REG_NONE);
  - UNMAPPED_DATA = 8'hFF;
  - default address constants.
- One sub-module, bus_clk_phase: divider, phase outputs, strobe-position ticks (ctr==0, ctr==1, ctr==H-1, wrap) and the cpu_reset counter.
- Decode, strobes and data latching stay in bus_ctrl.

Test Plan:
- Release reset with CPU_DIV_W=4 -> cpu_clk period 16 clk; cpu_clk high on ctr 8..15; cpu_reset falls after 8 cpu_clk rising edges.
- Write 8'hA5 to 16'h8401, NUM_PORTS=2 -> io_port[15:8]=8'hA5 after clk where ctr==7; io_port[7:0] unchanged; ram_we stays 0.
- Read 16'hF7FD with vdp_data=8'h3C -> exactly one vdp_read pulse at ctr==0; vdp_mode=2'b01; cpu_din=8'h3C at ctr==8.
- Read 16'hFFFC with rom_data=8'h00, then 16'h9000 -> cpu_din=8'h00, then 8'hFF (unmapped).
- Write 16'h1234 -> ram_we high for clk cycles ctr 0..7 only; no port or VDP strobe.
- Assert reset at ctr==5 during a port write -> io_port=0, ctr=0, cpu_reset=1 immediately; no write strobe is issued. With readback enabled, reading 16'h8400 after writing 8'h5A returns 8'h5A; with it disabled, returns 8'hFF.
